// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared constants and boot sequencer state encoding
package mips_ctrl_pkg;

  // Address and word widths shared by the sequencer, the pc and the instruction memory
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } boot_state_e;

  // The sequencer owns the core while loading, holding it in reset, or running it
  function automatic logic is_busy(input boot_state_e s);
    return (s == ST_LOAD) || (s == ST_HOLD) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down counter with zero flag
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load has priority; decrement saturates at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - loads a program into instruction memory, then runs the core for a cycle budget
module boot_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int RESET_CYCLES = 2,
  parameter int RUN_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [RUN_WIDTH-1:0]  run_cycles,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(1);

  boot_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
  logic [RUN_WIDTH-1:0]  run_cycles_q, run_cycles_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
  logic                  error_q, error_d;

  logic start_legal;
  logic handshake;
  logic hold_load, hold_en, hold_zero;
  logic run_load, run_en, run_zero;

  assign start_legal = (word_count != '0) && (word_count <= MAX_WORDS);

  // Abort gates in_ready combinationally so a coincident word is never accepted
  assign in_ready  = (state_q == ST_LOAD) && !abort;
  assign handshake = in_valid && in_ready;

  // Next-state, load bookkeeping and write-port staging
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    run_cycles_d = run_cycles_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    error_d      = 1'b0;
    hold_load    = 1'b0;
    hold_en      = 1'b0;
    run_load     = 1'b0;
    run_en       = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (start_legal) begin
              state_d      = ST_LOAD;
              addr_d       = '0;
              words_left_d = word_count;
              run_cycles_d = run_cycles;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = addr_q;
            imem_wdata_d = in_data;
            addr_d       = addr_q + ADDR_WIDTH'(1);
            words_left_d = words_left_q - LAST_WORD;
            if (words_left_q == LAST_WORD) begin
              state_d   = ST_HOLD;
              hold_load = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (hold_zero) begin
            state_d  = ST_RUN;
            run_load = 1'b1;
          end else begin
            hold_en = 1'b1;
          end
        end
        ST_RUN: begin
          // A zero budget means run until aborted
          if (run_cycles_q != '0) begin
            if (run_zero) begin
              state_d = ST_DONE;
            end else begin
              run_en = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
      run_cycles_q <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      run_cycles_q <= run_cycles_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      error_q      <= error_d;
    end
  end

  // HOLD lasts RESET_CYCLES cycles: loaded with RESET_CYCLES-1 on entry
  down_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load       (hold_load),
    .load_value (HOLD_LOAD),
    .en         (hold_en),
    .zero       (hold_zero)
  );

  // RUN lasts run_cycles cycles: loaded with run_cycles-1 on entry
  down_counter #(.WIDTH(RUN_WIDTH)) u_run_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .load       (run_load),
    .load_value (run_cycles_q - RUN_WIDTH'(1)),
    .en         (run_en),
    .zero       (run_zero)
  );

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign error      = error_q;
  assign cpu_reset  = (state_q != ST_RUN);
  assign busy       = is_busy(state_q);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - directed self-checking bench for boot_sequencer
module tb_boot_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [8:0]  word_count;
  logic [15:0] run_cycles;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  // write/run log, owned by the monitor
  int          cyc = 0;
  int          wr_cnt = 0;
  int          dup_cnt = 0;
  int          low_cnt = 0;
  int          last_we_cyc = 0;
  int          first_low_cyc = -1;
  int          clr_seen = 0;
  logic [31:0] mem [256];
  bit          written [256];

  int clr_gen = 0;

  boot_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .word_count (word_count),
    .run_cycles (run_cycles),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory model and core-out-of-reset cycle log
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      wr_cnt = 0;
      dup_cnt = 0;
      low_cnt = 0;
      last_we_cyc = 0;
      first_low_cyc = -1;
      for (int i = 0; i < 256; i++) begin
        mem[i] = '0;
        written[i] = 1'b0;
      end
    end
    if (imem_we === 1'b1) begin
      if (written[imem_addr]) dup_cnt = dup_cnt + 1;
      written[imem_addr] = 1'b1;
      mem[imem_addr] = imem_wdata;
      wr_cnt = wr_cnt + 1;
      last_we_cyc = cyc;
    end
    if (cpu_reset === 1'b0) begin
      low_cnt = low_cnt + 1;
      if (first_low_cyc < 0) first_low_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic clear_log();
    clr_gen = clr_gen + 1;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [8:0] wc, input logic [15:0] rc);
    start = 1'b1;
    word_count = wc;
    run_cycles = rc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = base + 32'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%0b want=1", cpu_reset); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_imem_we got=%0b want=0", imem_we); end
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_imem_addr got=%0h want=0", imem_addr); end
    total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_imem_wdata got=%0h want=0", imem_wdata); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL reset_flags got busy=%0b done=%0b error=%0b want 0/0/0", busy, done, error);
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (cpu_reset !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got cpu_reset=%0b in_ready=%0b want 1/0", cpu_reset, in_ready);
    end
  endtask

  task automatic test_load9();
    bit ok;
    clear_log();
    do_start(9'd9, 16'd5);
    total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL load_entry got in_ready=%0b busy=%0b want 1/1", in_ready, busy);
    end
    send_words(9, 32'hA500_0000);
    wait_done(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL load9_done_timeout got=0 want=1"); end
    total++; if (wr_cnt !== 9 || dup_cnt !== 0) begin
      bad++; $display("FAIL load9_writes got=%0d dup=%0d want 9 dup 0", wr_cnt, dup_cnt);
    end
    for (int i = 0; i < 9; i++) begin
      logic [31:0] exp;
      exp = 32'hA500_0000 + 32'(i);
      total++; if (mem[i] !== exp) begin bad++; $display("FAIL load9_mem[%0d] got=%0h want=%0h", i, mem[i], exp); end
    end
    total++; if (first_low_cyc - last_we_cyc !== 2) begin
      bad++; $display("FAIL load9_hold_gap got=%0d want=2", first_low_cyc - last_we_cyc);
    end
    total++; if (low_cnt !== 5) begin bad++; $display("FAIL load9_run_len got=%0d want=5", low_cnt); end
  endtask

  task automatic test_toggle_valid();
    bit ok;
    int idx;
    int c;
    clear_log();
    do_start(9'd3, 16'd2);
    idx = 0;
    c = 0;
    while (idx < 3 && c < 20) begin
      in_valid = (c % 2 == 0);
      in_data = 32'hB000_0000 + 32'(idx);
      @(negedge clk);
      if (in_valid) idx++;
      c++;
    end
    in_valid = 1'b1;
    in_data = 32'hBAD0_BAD0;
    wait_done(30, ok);
    in_valid = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL toggle_done_timeout got=0 want=1"); end
    total++; if (wr_cnt !== 3 || dup_cnt !== 0) begin
      bad++; $display("FAIL toggle_writes got=%0d dup=%0d want 3 dup 0", wr_cnt, dup_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp;
      exp = 32'hB000_0000 + 32'(i);
      total++; if (mem[i] !== exp) begin bad++; $display("FAIL toggle_mem[%0d] got=%0h want=%0h", i, mem[i], exp); end
    end
    total++; if (written[3] !== 1'b0) begin bad++; $display("FAIL toggle_extra_write got=1 want=0"); end
  endtask

  task automatic test_run20();
    bit ok;
    clear_log();
    do_start(9'd1, 16'd20);
    send_words(1, 32'hC000_0000);
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL run20_done_timeout got=0 want=1"); end
    total++; if (low_cnt !== 20) begin bad++; $display("FAIL run20_len got=%0d want=20", low_cnt); end
    total++; if (cpu_reset !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL run20_parked got cpu_reset=%0b busy=%0b want 1/0", cpu_reset, busy);
    end
    clear_log();
    do_start(9'd2, 16'd1);
    total++; if (done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_flags got done=%0b busy=%0b want 0/1", done, busy);
    end
    send_words(2, 32'hD000_0000);
    wait_done(20, ok);
    total++; if (!ok || wr_cnt !== 2 || mem[0] !== 32'hD000_0000 || mem[1] !== 32'hD000_0001) begin
      bad++; $display("FAIL restart_reload got writes=%0d m0=%0h m1=%0h want 2 d0000000 d0000001", wr_cnt, mem[0], mem[1]);
    end
  endtask

  task automatic test_bad_count();
    logic [8:0] wcs [2];
    wcs[0] = 9'd0;
    wcs[1] = 9'd257;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    clear_log();
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      word_count = wcs[k];
      @(negedge clk);
      start = 1'b0;
      total++; if (error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bad_wc%0d_pulse got error=%0b busy=%0b in_ready=%0b want 1/0/0", wcs[k], error, busy, in_ready);
      end
      @(negedge clk);
      total++; if (error !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL bad_wc%0d_after got error=%0b busy=%0b done=%0b want 0/0/0", wcs[k], error, busy, done);
      end
    end
    repeat (3) @(negedge clk);
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL bad_wc_writes got=%0d want=0", wr_cnt); end
  endtask

  task automatic test_full_load();
    bit ok;
    clear_log();
    do_start(9'd256, 16'd1);
    send_words(256, 32'hE000_0000);
    wait_done(20, ok);
    total++; if (!ok || wr_cnt !== 256 || dup_cnt !== 0) begin
      bad++; $display("FAIL full_writes got done=%0b writes=%0d dup=%0d want 1 256 0", ok, wr_cnt, dup_cnt);
    end
    total++; if (mem[0] !== 32'hE000_0000 || mem[128] !== 32'hE000_0080 || mem[255] !== 32'hE000_00FF) begin
      bad++; $display("FAIL full_mem got m0=%0h m128=%0h m255=%0h want e0000000 e0000080 e00000ff", mem[0], mem[128], mem[255]);
    end
  endtask

  task automatic test_abort_load();
    clear_log();
    do_start(9'd4, 16'd3);
    send_words(2, 32'hF000_0000);
    in_valid = 1'b1;
    in_data = 32'hF000_0002;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_pre_ready got=%0b want=1", in_ready); end
    abort = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_gate_ready got=%0b want=0", in_ready); end
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    total++; if (busy !== 1'b0 || cpu_reset !== 1'b1 || imem_we !== 1'b0) begin
      bad++; $display("FAIL abort_idle got busy=%0b cpu_reset=%0b imem_we=%0b want 0/1/0", busy, cpu_reset, imem_we);
    end
    repeat (3) @(negedge clk);
    total++; if (wr_cnt !== 2 || written[2] !== 1'b0) begin
      bad++; $display("FAIL abort_writes got=%0d w2=%0b want 2 w2=0", wr_cnt, written[2]);
    end
  endtask

  task automatic test_reset_mid_run();
    do_start(9'd1, 16'd0);
    send_words(1, 32'h1234_5678);
    repeat (30) @(negedge clk);
    total++; if (cpu_reset !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL infinite_run got cpu_reset=%0b busy=%0b want 0/1", cpu_reset, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    total++; if (cpu_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL async_reset_flags got cpu_reset=%0b busy=%0b done=%0b error=%0b in_ready=%0b want 1/0/0/0/0",
                      cpu_reset, busy, done, error, in_ready);
    end
    total++; if (imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
      bad++; $display("FAIL async_reset_port got we=%0b addr=%0h wdata=%0h want 0 0 0", imem_we, imem_addr, imem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_start(9'd1, 16'd0);
    send_words(1, 32'h8765_4321);
    repeat (25) @(negedge clk);
    total++; if (cpu_reset !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL zero_budget_run got cpu_reset=%0b done=%0b want 0/0", cpu_reset, done);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL abort_run got busy=%0b cpu_reset=%0b done=%0b want 0/1/0", busy, cpu_reset, done);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    word_count = '0;
    run_cycles = '0;
    in_valid = 1'b0;
    in_data = '0;
    test_reset();
    test_load9();
    test_toggle_valid();
    test_run20();
    test_bad_count();
    test_full_load();
    test_abort_load();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
